hamming_argmin: RTL

HAMMING_ARGMIN -- requirements
Module: hamming_argmin

---
 rtl/hamming_argmin.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hamming_argmin.sv
// Frame-wise argmin over a stream of Hamming distances: tracks the smallest
// distance, its first index, the number of candidates under threshold and the frame size.
module hamming_argmin #(
  parameter int DIST_W = 9,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIST_W-1:0] in_dist,
  input  logic              in_last,
  input  logic [DIST_W-1:0] threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIST_W-1:0] out_min_dist,
  output logic [IDX_W-1:0]  out_min_idx,
  output logic [IDX_W:0]    out_match_cnt,
  output logic [IDX_W:0]    out_count,
  output logic              out_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   FULL    = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]   CNT_MAX = FULL + CNT_ONE;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DIST_W-1:0] min_dist_q, min_dist_d;
  logic [DIST_W-1:0] thr_q, thr_d;
  logic [IDX_W-1:0]  min_idx_q, min_idx_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W:0]    match_q, match_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              post_sat;
  logic [IDX_W-1:0]  beat_idx;

  always_comb begin
    state_d    = state_q;
    min_dist_d = min_dist_q;
    thr_d      = thr_q;
    min_idx_d  = min_idx_q;
    idx_d      = idx_q;
    match_d    = match_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    accept   = in_valid && in_ready_q;
    // Once 2^IDX_W beats are in, every further beat shares the last index
    // and must not claim the minimum position.
    post_sat = (count_q >= FULL);
    beat_idx = post_sat ? IDX_MAX : idx_q + IDX_ONE;

    case (state_q)
      IDLE: begin
        if (accept) begin
          min_dist_d = in_dist;
          min_idx_d  = '0;
          idx_d      = '0;
          count_d    = CNT_ONE;
          thr_d      = threshold;
          match_d    = (in_dist <= threshold) ? CNT_ONE : '0;
          ovf_d      = 1'b0;
          state_d    = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (in_dist < min_dist_q) begin
            min_dist_d = in_dist;
            if (!post_sat) min_idx_d = beat_idx;
          end
          idx_d = beat_idx;
          if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
          if ((in_dist <= thr_q) && (match_q != FULL)) match_d = match_q + CNT_ONE;
          if (post_sat) ovf_d = 1'b1;
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      min_dist_q  <= '0;
      thr_q       <= '0;
      min_idx_q   <= '0;
      idx_q       <= '0;
      match_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      min_dist_q  <= min_dist_d;
      thr_q       <= thr_d;
      min_idx_q   <= min_idx_d;
      idx_q       <= idx_d;
      match_q     <= match_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_min_dist  = min_dist_q;
  assign out_min_idx   = min_idx_q;
  assign out_match_cnt = match_q;
  assign out_count     = count_q;
  assign out_overflow  = ovf_q;

endmodule
